// File: rtl/full_hash_pkg.sv
// Shared types and the round function for the full-hash core.
// Optional feature macro: FULL_HASH_LAST_CHECK_EN (see full_hash_param).
package full_hash_pkg;

   localparam int unsigned       HMAX       = 256;
   localparam logic [HMAX-1:0]   DEFAULT_IV = HMAX'(32'h6A09E667);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ROUND,
      S_LEN,
      S_DONE
   } state_e;

   function automatic int unsigned len_bytes(input int unsigned len_width);
      return len_width / 8;
   endfunction

   // Works on a HMAX-wide container; bits above h_width are masked off so the
   // result is the h_width-bit f(H,b,r).
   function automatic logic [HMAX-1:0] round_f(input logic [HMAX-1:0] h,
                                               input logic [7:0]      b,
                                               input logic [7:0]      r,
                                               input int unsigned     h_width,
                                               input int unsigned     rot_amt);
      logic [HMAX-1:0] mask;
      logic [HMAX-1:0] rep;
      logic [HMAX-1:0] x;
      logic [HMAX-1:0] rl;
      mask = (h_width >= HMAX) ? '1 : ((HMAX'(1) << h_width) - HMAX'(1));
      rep  = '0;
      for (int unsigned i = 0; i < HMAX / 8; i++) begin
         if (i < h_width / 8) rep[i*8 +: 8] = b ^ r;
      end
      x  = (h ^ rep) & mask;
      rl = ((x << rot_amt) | (x >> (h_width - rot_amt))) & mask;
      return (rl + (x >> 3)) & mask;
   endfunction

endpackage

// File: rtl/full_hash_round.sv
// Combinational round function f(H,b,r) of the full-hash core.
module full_hash_round
   import full_hash_pkg::*;
#(
   parameter int unsigned H_WIDTH = 32,
   parameter int unsigned ROT_AMT = 5
) (
   input  logic [H_WIDTH-1:0] h_i,
   input  logic [7:0]         byte_i,
   input  logic [7:0]         rnd_i,
   output logic [H_WIDTH-1:0] h_o
);

   assign h_o = H_WIDTH'(round_f(HMAX'(h_i), byte_i, rnd_i, H_WIDTH, ROT_AMT));

endmodule

// File: rtl/full_hash_param.sv
// Byte-serial full-hash core: absorbs msg_len bytes, then the length, and presents the digest.
// Optional macro FULL_HASH_LAST_CHECK_EN adds m_last termination and the len_err flag.
module full_hash_param
   import full_hash_pkg::*;
#(
   parameter int unsigned          H_WIDTH   = 32,
   parameter int unsigned          ROUNDS    = 4,
   parameter int unsigned          ROT_AMT   = 5,
   parameter int unsigned          LEN_WIDTH = 64,
   parameter logic [H_WIDTH-1:0]   IV        = H_WIDTH'(DEFAULT_IV)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] msg_len,
   output logic                 start_ready,
   input  logic                 m_valid,
   input  logic [7:0]           m_data,
   output logic                 m_ready,
   output logic                 busy,
   output logic [H_WIDTH-1:0]   digest,
   output logic                 digest_valid
`ifdef FULL_HASH_LAST_CHECK_EN
   ,
   input  logic                 m_last,
   output logic                 len_err
`endif
);

   localparam int unsigned LEN_BYTES = len_bytes(LEN_WIDTH);

   state_e                 state_q, state_d;
   logic [H_WIDTH-1:0]     h_q, h_f, digest_q;
   logic [LEN_WIDTH-1:0]   len_q, cnt_q;
   logic [31:0]            rnd_q, lb_q;
   logic [7:0]             byte_q, rb;
   logic                   start_ready_q, m_ready_q, busy_q, dv_q;
   logic                   rnd_last, lb_last, fin;
`ifdef FULL_HASH_LAST_CHECK_EN
   logic                   last_q, err_q;
`endif

   assign rnd_last = (rnd_q == 32'(ROUNDS - 1));
   assign lb_last  = (lb_q == 32'(LEN_BYTES - 1));
   // The length register is shifted right one byte per absorbed length byte.
   assign rb       = (state_q == S_LEN) ? len_q[7:0] : byte_q;
`ifdef FULL_HASH_LAST_CHECK_EN
   assign fin      = (cnt_q == len_q) || last_q;
`else
   assign fin      = (cnt_q == len_q);
`endif

   full_hash_round #(
      .H_WIDTH (H_WIDTH),
      .ROT_AMT (ROT_AMT)
   ) u_round (
      .h_i    (h_q),
      .byte_i (rb),
      .rnd_i  (rnd_q[7:0]),
      .h_o    (h_f)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (start) state_d = (msg_len == '0) ? S_LEN : S_WAIT;
         S_WAIT:         if (m_valid) state_d = S_ROUND;
         S_ROUND:        if (rnd_last) state_d = fin ? S_LEN : S_WAIT;
         S_LEN:          if (rnd_last && lb_last) state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         h_q           <= IV;
         len_q         <= '0;
         cnt_q         <= '0;
         rnd_q         <= '0;
         lb_q          <= '0;
         byte_q        <= '0;
         digest_q      <= '0;
         start_ready_q <= 1'b1;
         m_ready_q     <= 1'b0;
         busy_q        <= 1'b0;
         dv_q          <= 1'b0;
`ifdef FULL_HASH_LAST_CHECK_EN
         last_q        <= 1'b0;
         err_q         <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         start_ready_q <= (state_d == S_IDLE) || (state_d == S_DONE);
         m_ready_q     <= (state_d == S_WAIT);
         busy_q        <= (state_d == S_WAIT) || (state_d == S_ROUND) || (state_d == S_LEN);
         dv_q          <= (state_d == S_DONE);
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  h_q      <= IV;
                  len_q    <= msg_len;
                  cnt_q    <= '0;
                  rnd_q    <= '0;
                  lb_q     <= '0;
                  digest_q <= '0;
`ifdef FULL_HASH_LAST_CHECK_EN
                  last_q   <= 1'b0;
                  err_q    <= 1'b0;
`endif
               end
            end
            S_WAIT: begin
               if (m_valid) begin
                  byte_q <= m_data;
                  cnt_q  <= cnt_q + LEN_WIDTH'(1);
                  rnd_q  <= '0;
`ifdef FULL_HASH_LAST_CHECK_EN
                  last_q <= m_last;
`endif
               end
            end
            S_ROUND: begin
               h_q <= h_f;
               if (rnd_last) begin
                  rnd_q <= '0;
                  // LEN absorbs the count actually received (equal to msg_len unless cut by m_last).
                  if (fin) begin
                     len_q <= cnt_q;
`ifdef FULL_HASH_LAST_CHECK_EN
                     err_q <= (cnt_q == len_q) != last_q;
`endif
                  end
               end else begin
                  rnd_q <= rnd_q + 32'd1;
               end
            end
            S_LEN: begin
               h_q <= h_f;
               if (rnd_last) begin
                  rnd_q <= '0;
                  len_q <= len_q >> 8;
                  if (lb_last) digest_q <= h_f;
                  else         lb_q     <= lb_q + 32'd1;
               end else begin
                  rnd_q <= rnd_q + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign start_ready  = start_ready_q;
   assign m_ready      = m_ready_q;
   assign busy         = busy_q;
   assign digest       = digest_q;
   assign digest_valid = dv_q;
`ifdef FULL_HASH_LAST_CHECK_EN
   assign len_err      = err_q;
`endif

endmodule

// File: tb/tb_full_hash_param.sv
// Directed self-checking bench for full_hash_param at default parameters.
// Define FULL_HASH_LAST_CHECK_EN to also exercise m_last / len_err.
module tb_full_hash_param;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [63:0] msg_len;
   logic        start_ready;
   logic        m_valid;
   logic [7:0]  m_data;
   logic        m_ready;
   logic        busy;
   logic [31:0] digest;
   logic        digest_valid;
`ifdef FULL_HASH_LAST_CHECK_EN
   logic        m_last;
   logic        len_err;
`endif

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   localparam int unsigned NONE = 32'hFFFF_FFFF;

   always #5 clk = ~clk;

   full_hash_param #(
      .H_WIDTH   (32),
      .ROUNDS    (4),
      .ROT_AMT   (5),
      .LEN_WIDTH (64)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .msg_len      (msg_len),
      .start_ready  (start_ready),
      .m_valid      (m_valid),
      .m_data       (m_data),
      .m_ready      (m_ready),
      .busy         (busy),
      .digest       (digest),
      .digest_valid (digest_valid)
`ifdef FULL_HASH_LAST_CHECK_EN
      ,
      .m_last       (m_last),
      .len_err      (len_err)
`endif
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mdl_f(input logic [31:0] h, input logic [7:0] b, input int unsigned r);
      logic [7:0]  k;
      logic [31:0] x;
      k = b ^ 8'(r);
      x = h ^ {k, k, k, k};
      return {x[26:0], x[31:27]} + {3'b000, x[31:3]};
   endfunction

   // Absorb bytes 0..nbytes-1 (value = index), then lenval as 8 bytes LSB first.
   function automatic logic [31:0] mdl_hash(input int unsigned nbytes, input logic [63:0] lenval);
      logic [31:0] h;
      logic [63:0] l;
      h = 32'h6A09E667;
      for (int unsigned i = 0; i < nbytes; i++)
         for (int unsigned r = 0; r < 4; r++) h = mdl_f(h, 8'(i), r);
      l = lenval;
      for (int unsigned k = 0; k < 8; k++) begin
         for (int unsigned r = 0; r < 4; r++) h = mdl_f(h, l[7:0], r);
         l = l >> 8;
      end
      return h;
   endfunction

   task automatic do_hash(input int unsigned len, input int unsigned last_idx, input bit gappy,
                          output int unsigned lat, output logic [31:0] dig);
      int unsigned i;
      int unsigned e;
      int unsigned viol;
      bit          done;
      bit          acc;
      i = 0; e = 0; viol = 0; done = 1'b0;
      @(negedge clk);
      start   = 1'b1;
      msg_len = 64'(len);
      m_valid = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      check_eq("dv_drop_on_start", {63'd0, digest_valid}, 64'd0);
      check_eq("busy_after_start", {63'd0, busy}, 64'd1);
      while (!done && e < 2000) begin
         @(negedge clk);
         m_valid = (i < len) && (!gappy || e[0]);
         m_data  = 8'(i);
`ifdef FULL_HASH_LAST_CHECK_EN
         m_last  = (i == last_idx);
`endif
         acc = m_valid && m_ready;
         if (m_ready && !busy) viol++;
         @(posedge clk);
         e++;
         if (acc) i++;
         #1;
         if (digest_valid) done = 1'b1;
      end
      m_valid = 1'b0;
`ifdef FULL_HASH_LAST_CHECK_EN
      m_last  = 1'b0;
`endif
      check_eq("done_within_bound", {63'd0, done}, 64'd1);
      check_eq("m_ready_only_busy", 64'(viol), 64'd0);
      lat = e;
      dig = digest;
      if (last_idx == NONE) ;
   endtask

   int unsigned lat;
   logic [31:0] d, d26, d25, d10g;

   initial begin
      rst = 1'b1; start = 1'b0; m_valid = 1'b0; m_data = '0; msg_len = '0;
`ifdef FULL_HASH_LAST_CHECK_EN
      m_last = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_start_ready", {63'd0, start_ready}, 64'd1);
      check_eq("rst_m_ready", {63'd0, m_ready}, 64'd0);
      check_eq("rst_busy", {63'd0, busy}, 64'd0);
      check_eq("rst_dv", {63'd0, digest_valid}, 64'd0);
      check_eq("rst_digest", 64'(digest), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // 3 bytes gap-free: 3*5 + 32 = 47 edges
      do_hash(3, NONE, 1'b0, lat, d);
      check_eq("lat_len3", 64'(lat), 64'd47);
      check_eq("dig_len3", 64'(d), 64'(mdl_hash(3, 64'd3)));
      check_eq("sr_in_done", {63'd0, start_ready}, 64'd1);

      // zero length: only the 32 length rounds
      do_hash(0, NONE, 1'b0, lat, d);
      check_eq("lat_len0", 64'(lat), 64'd32);
      check_eq("dig_len0", 64'(d), 64'(mdl_hash(0, 64'd0)));

      do_hash(26, NONE, 1'b0, lat, d26);
      check_eq("lat_len26", 64'(lat), 64'd162);
      check_eq("dig_len26", 64'(d26), 64'(mdl_hash(26, 64'd26)));
      do_hash(25, NONE, 1'b0, lat, d25);
      check_eq("lat_len25", 64'(lat), 64'd157);
      check_eq("dig_len25", 64'(d25), 64'(mdl_hash(25, 64'd25)));
      check_eq("dig26_ne_dig25", {63'd0, d26 == d25}, 64'd0);
      do_hash(26, NONE, 1'b0, lat, d);
      check_eq("dig_len26_rerun", 64'(d), 64'(d26));

      // every other cycle idle: 82 + 10 idle WAIT cycles
      do_hash(10, NONE, 1'b1, lat, d10g);
      check_eq("lat_len10_gappy", 64'(lat), 64'd92);
      check_eq("dig_len10_gappy", 64'(d10g), 64'(mdl_hash(10, 64'd10)));
      do_hash(10, NONE, 1'b0, lat, d);
      check_eq("lat_len10", 64'(lat), 64'd82);
      check_eq("dig_len10_match", 64'(d), 64'(d10g));

      // reset during ROUND
      @(negedge clk);
      start = 1'b1; msg_len = 64'd2;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      m_valid = 1'b1; m_data = 8'h00;
      @(posedge clk); #1;
      m_valid = 1'b0;
      @(posedge clk); #1;
      check_eq("busy_in_round", {63'd0, busy}, 64'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check_eq("midrst_start_ready", {63'd0, start_ready}, 64'd1);
      check_eq("midrst_m_ready", {63'd0, m_ready}, 64'd0);
      check_eq("midrst_busy", {63'd0, busy}, 64'd0);
      check_eq("midrst_dv", {63'd0, digest_valid}, 64'd0);
      check_eq("midrst_digest", 64'(digest), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      do_hash(2, NONE, 1'b0, lat, d);
      check_eq("lat_len2_after_rst", 64'(lat), 64'd42);
      check_eq("dig_len2_after_rst", 64'(d), 64'(mdl_hash(2, 64'd2)));

`ifdef FULL_HASH_LAST_CHECK_EN
      // m_last on the third byte cuts the message; length absorbed is 3
      do_hash(5, 2, 1'b0, lat, d);
      check_eq("lat_early_last", 64'(lat), 64'd47);
      check_eq("dig_early_last", 64'(d), 64'(mdl_hash(3, 64'd3)));
      check_eq("len_err_early", {63'd0, len_err}, 64'd1);
      do_hash(5, 4, 1'b0, lat, d);
      check_eq("lat_exact_last", 64'(lat), 64'd57);
      check_eq("dig_exact_last", 64'(d), 64'(mdl_hash(5, 64'd5)));
      check_eq("len_err_exact", {63'd0, len_err}, 64'd0);
      // final byte without m_last still ends the message but flags an error
      do_hash(4, NONE, 1'b0, lat, d);
      check_eq("dig_no_last", 64'(d), 64'(mdl_hash(4, 64'd4)));
      check_eq("len_err_no_last", {63'd0, len_err}, 64'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
